// File: rtl/axis_layer_pkg.sv
// axis_layer_pkg: shared FSM state and frame-type encodings for the dense layer
package axis_layer_pkg;
    typedef enum logic [1:0] {RECV, DRAIN, FINISH, SEND} state_t;
    typedef enum logic {FRAME_INPUT = 1'b0, FRAME_WEIGHT = 1'b1} frame_t;
endpackage

// File: rtl/axis_dense_layer_if.sv
// axis_dense_layer_if: AXI-Stream bundle (tvalid/tready/tdata/tlast/tuser), master drives all but tready
interface axis_dense_layer_if #(
    parameter int WIDTH = 32
) ();
    logic tvalid;
    logic tready;
    logic signed [WIDTH-1:0] tdata;
    logic tlast;
    logic tuser;
    modport master(output tvalid, tdata, tlast, tuser, input tready);
    modport slave(input tvalid, tdata, tlast, tuser, output tready);
endinterface

// File: rtl/mac_unit.sv
// mac_unit: signed multiply-accumulate; ports axi_clk/axi_reset, clr (restart sum), en (add x*w), acc (running sum)
module mac_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int ACC_WIDTH  = 67
) (
    input  logic                         axi_clk,
    input  logic                         axi_reset,
    input  logic                         clr,
    input  logic                         en,
    input  logic signed [DATA_WIDTH-1:0] x,
    input  logic signed [DATA_WIDTH-1:0] w,
    output logic signed [ACC_WIDTH-1:0]  acc
);
    logic signed [2*DATA_WIDTH-1:0] p;
    logic signed [ACC_WIDTH-1:0] p_ext;
    assign p = x * w;
    assign p_ext = {{(ACC_WIDTH-2*DATA_WIDTH){p[2*DATA_WIDTH-1]}}, p};
    // clr and en together start a new sum with the first product
    always_ff @(posedge axi_clk)
        if (axi_reset)
            acc <= '0;
        else if (clr || en)
            acc <= (clr ? '0 : acc) + (en ? p_ext : '0);
endmodule

// File: rtl/axis_dense_layer.sv
// axis_dense_layer: AXI-Stream fully connected layer, N_OUT parallel MACs over N_IN-element input frames
// Ports: axi_clk, axi_reset (sync, active high); s_axis slave (tuser=1 weight frame, 0 input frame);
// m_axis master (one beat per neuron, tlast on the last); err_len one-cycle pulse on a bad frame length.
module axis_dense_layer
    import axis_layer_pkg::*;
#(
    parameter int N_IN       = 8,
    parameter int N_OUT      = 2,
    parameter int DATA_WIDTH = 32,
    parameter int RELU       = 0
) (
    input  logic axi_clk,
    input  logic axi_reset,
    axis_dense_layer_if.slave  s_axis,
    axis_dense_layer_if.master m_axis,
    output logic err_len
);
    localparam int ACC_WIDTH = 2*DATA_WIDTH + $clog2(N_IN);
    localparam int NW = N_IN * N_OUT;
    localparam int IW = $clog2(NW);
    localparam int OW = N_OUT > 1 ? $clog2(N_OUT) : 1;
    localparam logic [IW-1:0] LAST_W = IW'(NW - 1);
    localparam logic [IW-1:0] LAST_X = IW'(N_IN - 1);
    localparam logic [OW-1:0] LAST_O = OW'(N_OUT - 1);

    state_t state;
    frame_t ftype;
    frame_t cur;
    logic [IW-1:0] idx;
    logic [OW-1:0] oidx;
    logic [OW-1:0] nxt;
    logic s_fire, m_fire, recv_fire, at_end;
    logic signed [DATA_WIDTH-1:0] wmem [NW];
    logic signed [ACC_WIDTH-1:0] acc [N_OUT];

    function automatic logic signed [ACC_WIDTH-1:0] act(input logic signed [ACC_WIDTH-1:0] a);
        return (RELU != 0 && a[ACC_WIDTH-1]) ? '0 : a;
    endfunction

    assign s_fire = s_axis.tvalid && s_axis.tready;
    assign m_fire = m_axis.tvalid && m_axis.tready;
    assign recv_fire = s_fire && state == RECV;
    // frame type comes from tuser of the first beat, then from the latched copy
    assign cur = idx == '0 ? frame_t'(s_axis.tuser) : ftype;
    assign at_end = idx == (cur == FRAME_WEIGHT ? LAST_W : LAST_X);
    assign nxt = oidx + 1'b1;
    assign m_axis.tuser = 1'b0;

    for (genvar j = 0; j < N_OUT; j++) begin : g_mac
        localparam logic [IW-1:0] BASE = IW'(j * N_IN);
        mac_unit #(.DATA_WIDTH(DATA_WIDTH), .ACC_WIDTH(ACC_WIDTH)) u_mac (
            .axi_clk  (axi_clk),
            .axi_reset(axi_reset),
            .clr      (recv_fire && idx == '0),
            .en       (recv_fire && cur == FRAME_INPUT),
            .x        (s_axis.tdata),
            .w        (wmem[BASE + idx]),
            .acc      (acc[j])
        );
    end

    always_ff @(posedge axi_clk) begin
        if (axi_reset) begin
            state <= RECV;
            ftype <= FRAME_INPUT;
            idx <= '0;
            oidx <= '0;
            s_axis.tready <= 1'b0;
            m_axis.tvalid <= 1'b0;
            m_axis.tlast <= 1'b0;
            m_axis.tdata <= '0;
            err_len <= 1'b0;
            for (int i = 0; i < NW; i++) wmem[i] <= '0;
        end else begin
            err_len <= 1'b0;
            case (state)
                RECV: begin
                    s_axis.tready <= 1'b1;
                    if (s_fire) begin
                        if (idx == '0) ftype <= cur;
                        if (cur == FRAME_WEIGHT) wmem[idx] <= s_axis.tdata;
                        idx <= (at_end || s_axis.tlast) ? '0 : idx + 1'b1;
                        // early tlast and missing tlast are both a mismatch of these two
                        if (at_end != s_axis.tlast) err_len <= 1'b1;
                        if (at_end && !s_axis.tlast) state <= DRAIN;
                        if (at_end && s_axis.tlast && cur == FRAME_INPUT) begin
                            state <= FINISH;
                            s_axis.tready <= 1'b0;
                        end
                    end
                end
                DRAIN: if (s_fire && s_axis.tlast) state <= RECV;
                FINISH: begin
                    state <= SEND;
                    oidx <= '0;
                    m_axis.tvalid <= 1'b1;
                    m_axis.tdata <= act(acc[0]);
                    m_axis.tlast <= N_OUT == 1;
                end
                SEND: begin
                    if (m_fire) begin
                        if (oidx == LAST_O) begin
                            state <= RECV;
                            s_axis.tready <= 1'b1;
                            m_axis.tvalid <= 1'b0;
                            m_axis.tlast <= 1'b0;
                        end else begin
                            oidx <= nxt;
                            m_axis.tdata <= act(acc[nxt]);
                            m_axis.tlast <= nxt == LAST_O;
                        end
                    end
                end
                default: state <= RECV;
            endcase
        end
    end
endmodule

// File: tb/tb_axis_dense_layer.sv
// tb_axis_dense_layer: directed bench for axis_dense_layer (N_IN=4, N_OUT=2, DATA_WIDTH=8), RELU=0 and RELU=1 side by side
module tb_axis_dense_layer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst_s = 1'b1;
    logic s_valid, s_last, s_user, m_ready;
    logic signed [7:0] s_data;
    logic err0, err1;
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) rst_s <= rst;

    axis_dense_layer_if #(.WIDTH(8)) s0 ();
    axis_dense_layer_if #(.WIDTH(8)) s1 ();
    axis_dense_layer_if #(.WIDTH(18)) m0 ();
    axis_dense_layer_if #(.WIDTH(18)) m1 ();

    assign s0.tvalid = s_valid;
    assign s0.tdata = s_data;
    assign s0.tlast = s_last;
    assign s0.tuser = s_user;
    assign s1.tvalid = s_valid;
    assign s1.tdata = s_data;
    assign s1.tlast = s_last;
    assign s1.tuser = s_user;
    assign m0.tready = m_ready;
    assign m1.tready = m_ready;

    axis_dense_layer #(.N_IN(4), .N_OUT(2), .DATA_WIDTH(8), .RELU(0)) dut0 (
        .axi_clk(clk), .axi_reset(rst), .s_axis(s0), .m_axis(m0), .err_len(err0));
    axis_dense_layer #(.N_IN(4), .N_OUT(2), .DATA_WIDTH(8), .RELU(1)) dut1 (
        .axi_clk(clk), .axi_reset(rst), .s_axis(s1), .m_axis(m1), .err_len(err1));

    // frame-level reference: weights, collected inputs, pending results
    int mw [8];
    int xs [4];
    int cnt = 0;
    int flen;
    bit ftype = 1'b0;
    bit draining = 1'b0;
    bit hold = 1'b0;
    bit exp_err = 1'b0;
    longint rq [$];
    longint got0 [$], got1 [$];
    bit gl0 [$], gl1 [$];
    int e0 = 0;
    int e1 = 0;
    bit rdy, vld, lst, er;
    longint dat, sum;

    task automatic cmp(input string n, input longint got, input longint want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d at %0t", n, got, want, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // compare process: every cycle, DUT outputs against the reference
    always @(negedge clk) begin
        if (rst_s) begin
            cnt = 0; draining = 0; hold = 0; exp_err = 0; rq.delete();
            foreach (mw[i]) mw[i] = 0;
            rdy = 0; vld = 0; lst = 0; dat = 0; er = 0;
        end else begin
            rdy = !hold && rq.size() == 0;
            vld = !hold && rq.size() > 0;
            lst = vld && rq.size() == 1;
            dat = vld ? rq[0] : 0;
            er = exp_err;
        end
        cmp("s_tready", longint'(s0.tready), longint'(rdy));
        cmp("s_tready_relu", longint'(s1.tready), longint'(rdy));
        cmp("m_tvalid", longint'(m0.tvalid), longint'(vld));
        cmp("m_tvalid_relu", longint'(m1.tvalid), longint'(vld));
        cmp("err_len", longint'(err0), longint'(er));
        cmp("err_len_relu", longint'(err1), longint'(er));
        if (vld || rst_s) begin
            cmp("m_tlast", longint'(m0.tlast), longint'(lst));
            cmp("m_tlast_relu", longint'(m1.tlast), longint'(lst));
            cmp("m_tdata", longint'(m0.tdata), dat);
            cmp("m_tdata_relu", longint'(m1.tdata), dat < 0 ? 0 : dat);
        end
        if (!rst_s) begin
            exp_err = 0;
            if (hold) hold = 0;
            else if (vld && m_ready) void'(rq.pop_front());
            if (rdy && s_valid) begin
                if (draining) begin
                    if (s_last) draining = 0;
                end else begin
                    if (cnt == 0) ftype = s_user;
                    flen = ftype ? 8 : 4;
                    if (ftype) mw[cnt] = int'(s_data);
                    else xs[cnt] = int'(s_data);
                    cnt++;
                    if (cnt == flen) begin
                        cnt = 0;
                        if (!s_last) begin
                            exp_err = 1;
                            draining = 1;
                        end else if (!ftype) begin
                            for (int j = 0; j < 2; j++) begin
                                sum = 0;
                                for (int i = 0; i < 4; i++) sum += longint'(xs[i]) * longint'(mw[j*4+i]);
                                rq.push_back(sum);
                            end
                            hold = 1;
                        end
                    end else if (s_last) begin
                        exp_err = 1;
                        cnt = 0;
                    end
                end
            end
        end
    end

    // record what each DUT actually delivered
    always @(negedge clk) begin
        if (!rst_s) begin
            if (m0.tvalid && m_ready) begin
                got0.push_back(longint'(m0.tdata));
                gl0.push_back(m0.tlast);
            end
            if (m1.tvalid && m_ready) begin
                got1.push_back(longint'(m1.tdata));
                gl1.push_back(m1.tlast);
            end
            if (err0) e0++;
            if (err1) e1++;
        end
    end

    task automatic frame(input bit u, input int v [8], input int n, input int last_at);
        for (int k = 0; k < n; k++) begin
            int g = 0;
            s_valid = 1'b1;
            s_data = 8'(v[k]);
            s_last = (k == last_at);
            s_user = u;
            while (!s0.tready && g < 50) begin
                tick;
                g++;
            end
            if (g >= 50) cmp("ready_timeout", g, 0);
            tick;
        end
        s_valid = 1'b0;
        s_last = 1'b0;
    endtask

    task automatic wait_idle;
        int g = 0;
        tick;
        while ((rq.size() > 0 || hold || m0.tvalid) && g < 100) begin
            tick;
            g++;
        end
        if (g >= 100) cmp("idle_timeout", g, 0);
        tick;
    endtask

    task automatic expect_out(input string n, input longint a, input longint b, input longint c, input longint d);
        cmp({n, "_count"}, got0.size(), 2);
        cmp({n, "_count_relu"}, got1.size(), 2);
        if (got0.size() == 2) begin
            cmp({n, "_out0"}, got0[0], a);
            cmp({n, "_out1"}, got0[1], b);
            cmp({n, "_last0"}, longint'(gl0[0]), 0);
            cmp({n, "_last1"}, longint'(gl0[1]), 1);
        end
        if (got1.size() == 2) begin
            cmp({n, "_out0_relu"}, got1[0], c);
            cmp({n, "_out1_relu"}, got1[1], d);
        end
        got0.delete(); got1.delete(); gl0.delete(); gl1.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int lat;
        s_valid = 0; s_data = 0; s_last = 0; s_user = 0; m_ready = 1;
        repeat (3) tick;
        cmp("reset_s_tready", longint'(s0.tready), 0);
        cmp("reset_m_tdata", longint'(m0.tdata), 0);
        rst = 0;
        tick;
        cmp("post_reset_s_tready", longint'(s0.tready), 1);

        frame(1, '{1, 2, 3, 4, 5, 6, 7, 8}, 8, 7);
        frame(0, '{1, 2, 3, 4, 0, 0, 0, 0}, 4, 3);
        lat = 1;
        while (!m0.tvalid && lat < 10) begin
            tick;
            lat++;
        end
        cmp("latency", lat, 2);
        wait_idle;
        expect_out("basic", 30, 70, 30, 70);

        frame(0, '{-1, -1, -1, -1, 0, 0, 0, 0}, 4, 3);
        wait_idle;
        expect_out("negative", -10, -26, 0, 0);

        m_ready = 0;
        frame(0, '{1, 2, 3, 4, 0, 0, 0, 0}, 4, 3);
        tick;
        repeat (3) begin
            cmp("stall_tdata", longint'(m0.tdata), 30);
            cmp("stall_tvalid", longint'(m0.tvalid), 1);
            cmp("stall_s_tready", longint'(s0.tready), 0);
            tick;
        end
        m_ready = 1;
        wait_idle;
        expect_out("stall", 30, 70, 30, 70);

        e0 = 0; e1 = 0;
        frame(0, '{1, 2, 0, 0, 0, 0, 0, 0}, 2, 1);
        repeat (4) tick;
        cmp("early_err_pulses", e0, 1);
        cmp("early_err_pulses_relu", e1, 1);
        cmp("early_no_output", got0.size(), 0);
        frame(0, '{1, 2, 3, 4, 0, 0, 0, 0}, 4, 3);
        wait_idle;
        expect_out("after_early", 30, 70, 30, 70);

        e0 = 0; e1 = 0;
        frame(0, '{1, 2, 3, 4, 5, 6, 0, 0}, 6, 5);
        repeat (4) tick;
        cmp("long_err_pulses", e0, 1);
        cmp("long_no_output", got0.size(), 0);
        frame(0, '{1, 2, 3, 4, 0, 0, 0, 0}, 4, 3);
        wait_idle;
        expect_out("after_long", 30, 70, 30, 70);

        frame(0, '{1, 2, 0, 0, 0, 0, 0, 0}, 2, -1);
        rst = 1;
        repeat (2) tick;
        cmp("midreset_m_tvalid", longint'(m0.tvalid), 0);
        cmp("midreset_err_len", longint'(err0), 0);
        rst = 0;
        tick;
        frame(0, '{1, 2, 3, 4, 0, 0, 0, 0}, 4, 3);
        wait_idle;
        expect_out("after_reset", 0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/axis_dense_layer.md
AXIS_DENSE_LAYER -- requirements
Module: axis_dense_layer

Interface
REQ-001 SHALL have parameter N_IN, default 8, meaning input vector length (>=2).
REQ-002 SHALL have parameter N_OUT, default 2, meaning neuron count / output vector length (>=1).
REQ-003 SHALL have parameter DATA_WIDTH, default 32, meaning signed input and weight width.
REQ-004 SHALL have parameter RELU, default 0, meaning 1 clamps negative results to 0 and 0 passes results unchanged.
REQ-005 SHALL have localparam ACC_WIDTH = 2*DATA_WIDTH + $clog2(N_IN), meaning accumulator and output width.
REQ-006 SHALL have port axi_clk, input, 1, the single clock; all logic on its rising edge.
REQ-007 SHALL have port axi_reset, input, 1, a synchronous active-high reset.
REQ-008 SHALL have port s_axis_tvalid, input, 1, slave beat valid.
REQ-009 SHALL have port s_axis_tready, output, 1, slave beat ready.
REQ-010 SHALL have port s_axis_tdata, input, DATA_WIDTH, signed input or weight word.
REQ-011 SHALL have port s_axis_tlast, input, 1, last beat of frame.
REQ-012 SHALL have port s_axis_tuser, input, 1, frame type: 1 = weight frame, 0 = input frame; sampled on the first beat, ignored on the rest.
REQ-013 SHALL have port m_axis_tvalid, output, 1, master beat valid.
REQ-014 SHALL have port m_axis_tready, input, 1, master beat ready.
REQ-015 SHALL have port m_axis_tdata, output, ACC_WIDTH, signed neuron result.
REQ-016 SHALL have port m_axis_tlast, output, 1, asserted on neuron N_OUT-1.
REQ-017 SHALL have port err_len, output, 1, one-cycle pulse on a frame-length error.

Function
REQ-018 SHALL transfer a beat only when tvalid and tready are both high on a rising edge; transfers on both sides are independent.
REQ-019 SHALL implement states RECV, DRAIN, FINISH and SEND.
REQ-020 SHALL drive s_axis_tready = 1 in RECV and DRAIN, and 0 in FINISH and SEND.
REQ-021 SHALL drive m_axis_tvalid = 1 only in SEND.
REQ-022 SHALL store weight frame word k (k = 0..N_IN*N_OUT-1) as the weight of neuron k / N_IN, element k % N_IN.
REQ-023 SHALL require a weight frame to be exactly N_IN*N_OUT beats; weight registers take effect beat-by-beat, and a weight frame produces no output.
REQ-024 SHALL, for an input frame of exactly N_IN beats, have every neuron j accumulate acc_j += x_i * w_j,i in the cycle beat i is accepted; all N_OUT MACs run in parallel and acc is cleared at the start of each frame.
REQ-025 SHALL perform signed arithmetic: full-precision DATA_WIDTH x DATA_WIDTH products, sign-extended to ACC_WIDTH, with no overflow possible.
REQ-026 SHALL move RECV to FINISH on acceptance of the last input beat (index N_IN-1 with tlast=1); FINISH lasts one cycle and applies RELU; then SEND.
REQ-027 SHALL assert m_axis_tvalid with result 0 two cycles after the last input beat is accepted.
REQ-028 SHALL, in SEND, present results 0..N_OUT-1 in order, holding tdata and tlast stable while tready is low; after the beat N_OUT-1 transfers, return to RECV.
REQ-029 SHALL, on an early tlast (tlast=1 at index < expected-1), pulse err_len, discard the frame and stay in RECV at index 0; weights already written remain.
REQ-030 SHALL, on a missing tlast (tlast=0 at index expected-1), pulse err_len, enter DRAIN and discard beats up to and including the next tlast beat, then return to RECV.
REQ-031 SHALL not apply backpressure in RECV: back-to-back beats are accepted every cycle.

Reset
REQ-032 SHALL, while axi_reset is high, set state to RECV, clear indices, accumulators and all weights to 0, and drive s_axis_tready=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0 and err_len=0.
REQ-033 SHALL drive s_axis_tready=1 in the first cycle after reset deasserts.
REQ-034 SHALL, on a mid-frame or mid-SEND reset, abandon the frame or results with no partial output afterwards.

Structure
REQ-035 SHALL define the state enum and the frame-type encoding in the shared package axis_layer_pkg.
REQ-036 SHALL use one sub-module, mac_unit (signed multiply-accumulate with clear and enable), instantiated N_OUT times via generate.

Verification (N_IN=4, N_OUT=2, DATA_WIDTH=8)
REQ-037 SHALL cover: weight frame 1..8 then inputs 1,2,3,4 -> outputs 30 then 70 (tlast on 70), tvalid 2 cycles after the last input.
REQ-038 SHALL cover: RELU=1, weights 1..8, inputs -1,-1,-1,-1 -> outputs 0, 0; with RELU=0 -> -10, -26.
REQ-039 SHALL cover: m_axis_tready low 3 cycles in SEND -> tdata=30 held stable and s_axis_tready=0 throughout.
REQ-040 SHALL cover: input tlast on beat 2 -> err_len one pulse, no m_axis_tvalid, next good frame gives 30, 70.
REQ-041 SHALL cover: 6-beat input frame with tlast on beat 6 -> err_len at beat 4, beats 5-6 drained, no output.
REQ-042 SHALL cover: reset asserted after beat 2 -> all outputs 0; post-reset input frame 1,2,3,4 -> outputs 0, 0 (weights cleared).
